// File: rtl/keshe_pkg.sv
// rtl/keshe_pkg.sv - shared state, display-mode and buzzer-source codes for mode_sequencer
package keshe_pkg;

  // Sequencer states; the three countdown states all share the countdown display.
  typedef enum logic [2:0] {
    ST_CLK      = 3'd0,
    ST_SET_T    = 3'd1,
    ST_SET_A    = 3'd2,
    ST_CD_SET   = 3'd3,
    ST_CD_RUN   = 3'd4,
    ST_CD_PAUSE = 3'd5
  } state_t;

  // Display/data select codes.
  localparam logic [1:0] MODE_CLOCK     = 2'b00;
  localparam logic [1:0] MODE_SET_TIME  = 2'b01;
  localparam logic [1:0] MODE_SET_ALARM = 2'b10;
  localparam logic [1:0] MODE_COUNTDOWN = 2'b11;

  // Buzzer source codes.
  localparam logic [1:0] RING_CHIME = 2'b00;
  localparam logic [1:0] RING_ALARM = 2'b01;
  localparam logic [1:0] RING_CD    = 2'b10;
  localparam logic [1:0] RING_MUTED = 2'b11;

endpackage

// File: rtl/key_edge.sv
// rtl/key_edge.sv - two-flop synchronizer plus rising-edge detector for one raw button
module key_edge (
  input  logic CP,
  input  logic CR,
  input  logic key,
  output logic pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // Bring the asynchronous level into the CP domain and keep one cycle of history.
  always_ff @(posedge CP) begin
    if (CR) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
    end else begin
      sync_1    <= key;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
    end
  end

  // High for exactly one cycle per press, however long the button is held.
  assign pulse = sync_2 & ~sync_prev;

endmodule

// File: rtl/mode_sequencer.sv
// rtl/mode_sequencer.sv - button-driven mode FSM for clock, time/alarm set and countdown
module mode_sequencer
  import keshe_pkg::*;
#(
  parameter int TIMEOUT_S = 30
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       TICK,
  input  logic       KEY_MODE,
  input  logic       LEAD,
  input  logic       EXPORT,
  input  logic       CS,
  input  logic       TC_ALARM,
  input  logic       TC_CD,
  output logic [1:0] MODE,
  output logic       LEAD_TIMER,
  output logic       LEAD_ALARM,
  output logic       EXPORT_SET,
  output logic       CD_LOAD,
  output logic       CD_RUN,
  output logic [1:0] RING
);

  // Idle count at which the next TICK ends the set mode.
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);

  state_t     state;
  logic [7:0] idle_cnt;
  logic       export_pend;
  logic       tc_cd_d;
  logic       mute;

  logic       mode_ev;
  logic       lead_ev;
  logic       export_ev;
  logic       cs_ev;
  logic       fsm_ev;
  logic       any_ev;
  logic       idle_state;
  logic       timeout;
  logic       tc_cd_rise;

  key_edge u_key_mode (.CP(CP), .CR(CR), .key(KEY_MODE), .pulse(mode_ev));
  key_edge u_key_lead (.CP(CP), .CR(CR), .key(LEAD),     .pulse(lead_ev));
  key_edge u_key_exp  (.CP(CP), .CR(CR), .key(EXPORT),   .pulse(export_ev));
  key_edge u_key_cs   (.CP(CP), .CR(CR), .key(CS),       .pulse(cs_ev));

  assign fsm_ev     = mode_ev | lead_ev | export_ev;
  assign any_ev     = fsm_ev | cs_ev;
  assign idle_state = (state == ST_SET_T) || (state == ST_SET_A) || (state == ST_CD_SET);
  assign timeout    = idle_state && TICK && (idle_cnt == IDLE_LAST);
  assign tc_cd_rise = TC_CD & ~tc_cd_d;

  // Mode FSM with registered mode, pulse and run outputs; events are taken in
  // KEY_MODE > LEAD > EXPORT order and the lower ones that cycle are dropped.
  always_ff @(posedge CP) begin
    if (CR) begin
      state       <= ST_CLK;
      MODE        <= MODE_CLOCK;
      LEAD_TIMER  <= 1'b0;
      LEAD_ALARM  <= 1'b0;
      EXPORT_SET  <= 1'b0;
      CD_LOAD     <= 1'b0;
      CD_RUN      <= 1'b0;
      export_pend <= 1'b0;
      idle_cnt    <= 8'd0;
      tc_cd_d     <= 1'b0;
    end else begin
      LEAD_TIMER  <= 1'b0;
      LEAD_ALARM  <= 1'b0;
      CD_LOAD     <= 1'b0;
      // The entry export fires one cycle after entering a set mode, unless a
      // key event that same cycle produces its own pulse or moves the state on.
      EXPORT_SET  <= export_pend && !fsm_ev;
      export_pend <= 1'b0;
      tc_cd_d     <= TC_CD;

      if (tc_cd_rise) begin
        CD_RUN <= 1'b0;
      end

      if (any_ev || !idle_state || timeout) begin
        idle_cnt <= 8'd0;
      end else if (TICK) begin
        idle_cnt <= idle_cnt + 8'd1;
      end

      case (state)
        ST_CLK: begin
          if (mode_ev) begin
            state       <= ST_SET_T;
            MODE        <= MODE_SET_TIME;
            export_pend <= 1'b1;
          end
        end

        ST_SET_T: begin
          if (mode_ev) begin
            state       <= ST_SET_A;
            MODE        <= MODE_SET_ALARM;
            export_pend <= 1'b1;
          end else if (lead_ev) begin
            LEAD_TIMER <= 1'b1;
            state      <= ST_CLK;
            MODE       <= MODE_CLOCK;
          end else if (export_ev) begin
            EXPORT_SET <= 1'b1;
          end else if (timeout) begin
            state <= ST_CLK;
            MODE  <= MODE_CLOCK;
          end
        end

        ST_SET_A: begin
          if (mode_ev) begin
            state <= ST_CD_SET;
            MODE  <= MODE_COUNTDOWN;
            CD_RUN <= 1'b0;
          end else if (lead_ev) begin
            LEAD_ALARM <= 1'b1;
            state      <= ST_CLK;
            MODE       <= MODE_CLOCK;
          end else if (export_ev) begin
            EXPORT_SET <= 1'b1;
          end else if (timeout) begin
            state <= ST_CLK;
            MODE  <= MODE_CLOCK;
          end
        end

        ST_CD_SET: begin
          if (mode_ev) begin
            state <= ST_CLK;
            MODE  <= MODE_CLOCK;
          end else if (lead_ev) begin
            CD_LOAD <= 1'b1;
            CD_RUN  <= 1'b1;
            state   <= ST_CD_RUN;
          end else if (timeout) begin
            state <= ST_CLK;
            MODE  <= MODE_CLOCK;
          end
        end

        ST_CD_RUN: begin
          // Leaving to the clock display keeps the countdown running behind it.
          if (mode_ev) begin
            state <= ST_CLK;
            MODE  <= MODE_CLOCK;
          end else if (export_ev) begin
            state  <= ST_CD_PAUSE;
            CD_RUN <= 1'b0;
          end else if (tc_cd_rise) begin
            state <= ST_CD_SET;
          end
        end

        ST_CD_PAUSE: begin
          if (mode_ev) begin
            state <= ST_CLK;
            MODE  <= MODE_CLOCK;
          end else if (lead_ev) begin
            state  <= ST_CD_RUN;
            CD_RUN <= 1'b1;
          end else if (export_ev) begin
            state  <= ST_CD_SET;
            CD_RUN <= 1'b0;
          end
        end

        default: begin
          state <= ST_CLK;
          MODE  <= MODE_CLOCK;
        end
      endcase
    end
  end

  // Buzzer source select; a CS press mutes the current ring requests until both drop.
  always_ff @(posedge CP) begin
    if (CR) begin
      mute <= 1'b0;
      RING <= RING_CHIME;
    end else if (!(TC_ALARM || TC_CD)) begin
      mute <= 1'b0;
      RING <= RING_CHIME;
    end else if (mute || cs_ev) begin
      mute <= 1'b1;
      RING <= RING_MUTED;
    end else if (TC_CD) begin
      RING <= RING_CD;
    end else begin
      RING <= RING_ALARM;
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// tb/tb_mode_sequencer.sv - directed self-checking bench for mode_sequencer
module tb_mode_sequencer;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       TICK = 1'b0;
  logic       KEY_MODE = 1'b0;
  logic       LEAD = 1'b0;
  logic       EXPORT = 1'b0;
  logic       CS = 1'b0;
  logic       TC_ALARM = 1'b0;
  logic       TC_CD = 1'b0;
  logic [1:0] MODE;
  logic       LEAD_TIMER;
  logic       LEAD_ALARM;
  logic       EXPORT_SET;
  logic       CD_LOAD;
  logic       CD_RUN;
  logic [1:0] RING;

  int tests = 0;
  int fails = 0;

  int n_lt = 0;
  int n_la = 0;
  int n_ex = 0;
  int n_ld = 0;
  int n_multi = 0;

  mode_sequencer #(.TIMEOUT_S(3)) dut (
    .CP(CP), .CR(CR), .TICK(TICK),
    .KEY_MODE(KEY_MODE), .LEAD(LEAD), .EXPORT(EXPORT), .CS(CS),
    .TC_ALARM(TC_ALARM), .TC_CD(TC_CD),
    .MODE(MODE), .LEAD_TIMER(LEAD_TIMER), .LEAD_ALARM(LEAD_ALARM),
    .EXPORT_SET(EXPORT_SET), .CD_LOAD(CD_LOAD), .CD_RUN(CD_RUN), .RING(RING)
  );

  always #5 CP = ~CP;

  // Pulse counters sampled on the falling edge, away from the register updates.
  always @(negedge CP) begin
    if (LEAD_TIMER === 1'b1) n_lt <= n_lt + 1;
    if (LEAD_ALARM === 1'b1) n_la <= n_la + 1;
    if (EXPORT_SET === 1'b1) n_ex <= n_ex + 1;
    if (CD_LOAD === 1'b1)    n_ld <= n_ld + 1;
    if ((int'(LEAD_TIMER) + int'(LEAD_ALARM) + int'(EXPORT_SET) + int'(CD_LOAD)) > 1)
      n_multi <= n_multi + 1;
  end

  task automatic press(input logic km, input logic ld, input logic ex, input logic cs);
    @(negedge CP);
    KEY_MODE = km; LEAD = ld; EXPORT = ex; CS = cs;
    repeat (3) @(negedge CP);
    KEY_MODE = 1'b0; LEAD = 1'b0; EXPORT = 1'b0; CS = 1'b0;
    repeat (4) @(negedge CP);
  endtask

  task automatic tick_once();
    @(negedge CP);
    TICK = 1'b1;
    @(negedge CP);
    TICK = 1'b0;
  endtask

  task automatic test_reset();
    CR = 1'b1;
    repeat (3) @(negedge CP);
    tests++; if (MODE !== 2'b00) begin fails++; $display("FAIL reset_mode: got %b want 00", MODE); end
    tests++; if ({LEAD_TIMER, LEAD_ALARM, EXPORT_SET, CD_LOAD} !== 4'b0000) begin
      fails++; $display("FAIL reset_pulses: got %b want 0000", {LEAD_TIMER, LEAD_ALARM, EXPORT_SET, CD_LOAD}); end
    tests++; if (CD_RUN !== 1'b0) begin fails++; $display("FAIL reset_cd_run: got %b want 0", CD_RUN); end
    tests++; if (RING !== 2'b00) begin fails++; $display("FAIL reset_ring: got %b want 00", RING); end
    CR = 1'b0;
    repeat (2) @(negedge CP);
  endtask

  task automatic test_mode_cycle();
    logic [1:0] want_mode [4];
    int want_ex [4];
    int e0;
    want_mode[0] = 2'b01; want_mode[1] = 2'b10; want_mode[2] = 2'b11; want_mode[3] = 2'b00;
    want_ex[0] = 1; want_ex[1] = 2; want_ex[2] = 2; want_ex[3] = 2;
    e0 = n_ex;
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 1'b0, 1'b0, 1'b0);
      tests++; if (MODE !== want_mode[i]) begin
        fails++; $display("FAIL mode_cycle_%0d: MODE=%b want %b", i, MODE, want_mode[i]); end
      tests++; if (n_ex - e0 !== want_ex[i]) begin
        fails++; $display("FAIL mode_cycle_export_%0d: pulses=%0d want %0d", i, n_ex - e0, want_ex[i]); end
    end
  endtask

  task automatic test_lead_set_t();
    int lt0;
    int la0;
    bit seen;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    lt0 = n_lt; la0 = n_la; seen = 0;
    @(negedge CP);
    LEAD = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CP);
      if (i == 3) LEAD = 1'b0;
      if (!seen && LEAD_TIMER === 1'b1) begin
        seen = 1;
        tests++; if (MODE !== 2'b00) begin
          fails++; $display("FAIL lead_mode_with_pulse: MODE=%b want 00", MODE); end
      end
    end
    tests++; if (!seen) begin fails++; $display("FAIL lead_timer_seen: got 0 want 1"); end
    tests++; if (n_lt - lt0 !== 1) begin fails++; $display("FAIL lead_timer_count: got %0d want 1", n_lt - lt0); end
    tests++; if (n_la - la0 !== 0) begin fails++; $display("FAIL lead_alarm_count: got %0d want 0", n_la - la0); end
  endtask

  task automatic test_export_reexport();
    int e0;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    e0 = n_ex;
    press(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (n_ex - e0 !== 1) begin fails++; $display("FAIL reexport_count: got %0d want 1", n_ex - e0); end
    tests++; if (MODE !== 2'b01) begin fails++; $display("FAIL reexport_mode: got %b want 01", MODE); end
    repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (MODE !== 2'b00) begin fails++; $display("FAIL reexport_back: got %b want 00", MODE); end
  endtask

  task automatic test_countdown();
    int l0;
    repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (MODE !== 2'b11) begin fails++; $display("FAIL cd_mode: got %b want 11", MODE); end
    l0 = n_ld;
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (n_ld - l0 !== 1) begin fails++; $display("FAIL cd_load_count: got %0d want 1", n_ld - l0); end
    tests++; if (CD_RUN !== 1'b1) begin fails++; $display("FAIL cd_run_start: got %b want 1", CD_RUN); end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (CD_RUN !== 1'b0) begin fails++; $display("FAIL cd_run_pause: got %b want 0", CD_RUN); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (CD_RUN !== 1'b1) begin fails++; $display("FAIL cd_run_resume: got %b want 1", CD_RUN); end
    tests++; if (n_ld - l0 !== 1) begin fails++; $display("FAIL cd_resume_no_load: got %0d want 1", n_ld - l0); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (MODE !== 2'b00) begin fails++; $display("FAIL cd_leave_mode: got %b want 00", MODE); end
    tests++; if (CD_RUN !== 1'b1) begin fails++; $display("FAIL cd_run_held: got %b want 1", CD_RUN); end
    @(negedge CP); TC_CD = 1'b1;
    repeat (3) @(negedge CP);
    tests++; if (CD_RUN !== 1'b0) begin fails++; $display("FAIL cd_run_tc_clear: got %b want 0", CD_RUN); end
    tests++; if (RING !== 2'b10) begin fails++; $display("FAIL cd_ring: got %b want 10", RING); end
    TC_CD = 1'b0;
    repeat (3) @(negedge CP);
    tests++; if (RING !== 2'b00) begin fails++; $display("FAIL cd_ring_off: got %b want 00", RING); end
  endtask

  task automatic test_timeout();
    int la0;
    repeat (2) press(1'b1, 1'b0, 1'b0, 1'b0);
    la0 = n_la;
    tests++; if (MODE !== 2'b10) begin fails++; $display("FAIL timeout_enter: got %b want 10", MODE); end
    tick_once();
    tick_once();
    repeat (2) @(negedge CP);
    tests++; if (MODE !== 2'b10) begin fails++; $display("FAIL timeout_early: got %b want 10", MODE); end
    tick_once();
    tests++; if (MODE !== 2'b00) begin fails++; $display("FAIL timeout_expire: got %b want 00", MODE); end
    repeat (3) @(negedge CP);
    tests++; if (n_la - la0 !== 0) begin fails++; $display("FAIL timeout_no_lead: got %0d want 0", n_la - la0); end
  endtask

  task automatic test_ring();
    @(negedge CP); TC_ALARM = 1'b1;
    repeat (2) @(negedge CP);
    tests++; if (RING !== 2'b01) begin fails++; $display("FAIL ring_alarm: got %b want 01", RING); end
    TC_CD = 1'b1;
    repeat (2) @(negedge CP);
    tests++; if (RING !== 2'b10) begin fails++; $display("FAIL ring_cd_prio: got %b want 10", RING); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (RING !== 2'b11) begin fails++; $display("FAIL ring_muted: got %b want 11", RING); end
    TC_CD = 1'b0;
    repeat (2) @(negedge CP);
    tests++; if (RING !== 2'b11) begin fails++; $display("FAIL ring_still_muted: got %b want 11", RING); end
    TC_ALARM = 1'b0;
    repeat (2) @(negedge CP);
    tests++; if (RING !== 2'b00) begin fails++; $display("FAIL ring_unmute: got %b want 00", RING); end
    TC_ALARM = 1'b1;
    repeat (2) @(negedge CP);
    tests++; if (RING !== 2'b01) begin fails++; $display("FAIL ring_mute_cleared: got %b want 01", RING); end
    TC_ALARM = 1'b0;
    repeat (2) @(negedge CP);
  endtask

  task automatic test_simultaneous();
    int lt0;
    int e0;
    press(1'b1, 1'b0, 1'b0, 1'b0);
    lt0 = n_lt; e0 = n_ex;
    press(1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (MODE !== 2'b10) begin fails++; $display("FAIL simul_mode: got %b want 10", MODE); end
    tests++; if (n_lt - lt0 !== 0) begin fails++; $display("FAIL simul_no_lead: got %0d want 0", n_lt - lt0); end
    tests++; if (n_ex - e0 !== 1) begin fails++; $display("FAIL simul_export: got %0d want 1", n_ex - e0); end
    repeat (2) press(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int lt0;
    // Reset landing on the edge that would register LEAD_TIMER.
    press(1'b1, 1'b0, 1'b0, 1'b0);
    lt0 = n_lt;
    @(negedge CP); LEAD = 1'b1;
    repeat (2) @(negedge CP);
    CR = 1'b1;
    @(negedge CP);
    tests++; if (LEAD_TIMER !== 1'b0) begin fails++; $display("FAIL rst_suppress_pulse: got %b want 0", LEAD_TIMER); end
    tests++; if (MODE !== 2'b00) begin fails++; $display("FAIL rst_suppress_mode: got %b want 00", MODE); end
    LEAD = 1'b0;
    @(negedge CP); CR = 1'b0;
    repeat (4) @(negedge CP);
    tests++; if (n_lt - lt0 !== 0) begin fails++; $display("FAIL rst_suppress_count: got %0d want 0", n_lt - lt0); end
    // Reset in the middle of a running countdown with a ring request active.
    repeat (3) press(1'b1, 1'b0, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (CD_RUN !== 1'b1) begin fails++; $display("FAIL rst_pre_cd_run: got %b want 1", CD_RUN); end
    TC_ALARM = 1'b1;
    repeat (3) @(negedge CP);
    CR = 1'b1;
    @(negedge CP);
    tests++; if ({MODE, CD_RUN, RING} !== 5'b00000) begin
      fails++; $display("FAIL rst_mid_outputs: MODE/CD_RUN/RING=%b want 00000", {MODE, CD_RUN, RING}); end
    tests++; if ({LEAD_TIMER, LEAD_ALARM, EXPORT_SET, CD_LOAD} !== 4'b0000) begin
      fails++; $display("FAIL rst_mid_pulses: got %b want 0000", {LEAD_TIMER, LEAD_ALARM, EXPORT_SET, CD_LOAD}); end
    TC_ALARM = 1'b0;
    @(negedge CP); CR = 1'b0;
    repeat (3) @(negedge CP);
    tests++; if (MODE !== 2'b00) begin fails++; $display("FAIL rst_after_mode: got %b want 00", MODE); end
  endtask

  task automatic test_onehot();
    tests++; if (n_multi !== 0) begin fails++; $display("FAIL pulse_onehot: overlap cycles=%0d want 0", n_multi); end
  endtask

  initial begin
    test_reset();
    test_mode_cycle();
    test_lead_set_t();
    test_export_reexport();
    test_countdown();
    test_timeout();
    test_ring();
    test_simultaneous();
    test_reset_mid();
    test_onehot();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
